// File: rtl/pw_arbiter_pkg.sv
// rtl/pw_arbiter_pkg.sv - shared page-walk request/result types and requester IDs
package pw_arbiter_pkg;

  // Requester IDs: instruction fetch is always 0, data ports follow.
  localparam int RQ_IFETCH = 0;
  localparam int RQ_LOAD   = 1;
  localparam int RQ_STORE  = 2;

  // Width of the rqID field carried in the broadcast result.
  localparam int RQ_ID_W = 2;

  typedef struct packed {
    logic        valid;
    logic [31:0] vaddr;
  } PageWalk_Req;

  typedef struct packed {
    logic               busy;
    logic [RQ_ID_W-1:0] rqID;
    logic               fault;
    logic [19:0]        ppn;
    logic [31:0]        vaddr;
  } PageWalk_Res;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DRAIN
  } pw_state_e;

  // Round-robin pointer advance: one past idx, wrapping at n.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/pw_arbiter_rr_picker.sv
// rtl/pw_arbiter_rr_picker.sv - one-hot round-robin picker starting at ptr
module rr_picker #(
  parameter int NUM_RQ = 3,
  parameter int ID_W   = $clog2(NUM_RQ)
) (
  input  logic [NUM_RQ-1:0] mask,
  input  logic [ID_W-1:0]   ptr,
  output logic [NUM_RQ-1:0] onehot,
  output logic [ID_W-1:0]   idx,
  output logic              found
);

  // First set bit at or above ptr; failing that, the first set bit from 0 (wrap).
  always_comb begin
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    for (int i = 0; i < NUM_RQ; i++) begin
      if (!found && mask[i] && (ID_W'(i) >= ptr)) begin
        found     = 1'b1;
        onehot[i] = 1'b1;
        idx       = ID_W'(i);
      end
    end
    for (int i = 0; i < NUM_RQ; i++) begin
      if (!found && mask[i]) begin
        found     = 1'b1;
        onehot[i] = 1'b1;
        idx       = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/pw_arbiter.sv
// rtl/pw_arbiter.sv - round-robin arbiter sharing one page walker among TLB ports
module pw_arbiter
  import pw_arbiter_pkg::*;
#(
  parameter int NUM_RQ = 3,
  parameter int ID_W   = $clog2(NUM_RQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  PageWalk_Req       IN_req [NUM_RQ],
  output logic [NUM_RQ-1:0] OUT_grant,
  input  logic [NUM_RQ-1:0] IN_cancel,
  input  logic              IN_clear,
  output PageWalk_Req       OUT_walk,
  output logic [ID_W-1:0]   OUT_walkRqID,
  input  logic              IN_walkDone,
  input  PageWalk_Res       IN_walkRes,
  output PageWalk_Res       OUT_res,
  output logic              OUT_resValid
);

  pw_state_e         state;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   cur_id;
  logic              stale;
  logic              late_walk_ok;

  logic [NUM_RQ-1:0] cand_mask;
  logic [NUM_RQ-1:0] pick_onehot;
  logic [ID_W-1:0]   win_idx;
  logic              win_found;
  logic              flush_cur;
  PageWalk_Res       res_next;

  // A requester competes only if it is asking and not being flushed this cycle.
  always_comb begin
    for (int i = 0; i < NUM_RQ; i++) begin
      cand_mask[i] = IN_req[i].valid && !IN_cancel[i];
    end
  end

  rr_picker #(
    .NUM_RQ (NUM_RQ),
    .ID_W   (ID_W)
  ) u_picker (
    .mask   (cand_mask),
    .ptr    (rr_ptr),
    .onehot (pick_onehot),
    .idx    (win_idx),
    .found  (win_found)
  );

  assign OUT_grant    = (state == ST_IDLE) ? pick_onehot : '0;
  assign OUT_walkRqID = cur_id;
  assign flush_cur    = IN_cancel[cur_id] || IN_clear;

  // Walker payload passes through; busy/rqID are owned by this block.
  always_comb begin
    res_next      = IN_walkRes;
    res_next.busy = IN_clear;
    res_next.rqID = RQ_ID_W'(cur_id);
  end

  // Arbitration FSM with registered walk, result and busy outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      rr_ptr       <= '0;
      cur_id       <= '0;
      stale        <= 1'b0;
      OUT_walk     <= '0;
      OUT_res      <= '0;
      OUT_resValid <= 1'b0;
    end else begin
      OUT_walk.valid <= 1'b0;
      OUT_resValid   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (win_found) begin
            OUT_walk       <= IN_req[win_idx];
            OUT_walk.valid <= 1'b1;
            cur_id         <= win_idx;
            rr_ptr         <= ID_W'(wrap_inc(int'(win_idx), NUM_RQ));
            stale          <= 1'b0;
            OUT_res.busy   <= 1'b1;
            OUT_res.rqID   <= RQ_ID_W'(win_idx);
            state          <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (flush_cur) stale <= 1'b1;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (IN_walkDone) begin
            OUT_res      <= res_next;
            OUT_resValid <= !(stale || flush_cur);
            state        <= IN_clear ? ST_DRAIN : ST_IDLE;
          end else if (flush_cur) begin
            stale <= 1'b1;
          end
        end
        ST_DRAIN: begin
          OUT_res.busy <= 1'b0;
          state        <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // A reset that cuts a walk short leaves one legitimate late walkDone to absorb.
  always_ff @(posedge clk) begin
    if (rst) begin
      late_walk_ok <= late_walk_ok || (state == ST_ISSUE) || (state == ST_WAIT);
    end else if (IN_walkDone) begin
      late_walk_ok <= 1'b0;
    end
  end

  a_done_in_wait : assert property (@(posedge clk) disable iff (rst)
    !(IN_walkDone && (state != ST_WAIT) && !late_walk_ok));

endmodule

// File: tb/tb_pw_arbiter.sv
// tb/tb_pw_arbiter.sv - self-checking bench for pw_arbiter
module tb_pw_arbiter;
  import pw_arbiter_pkg::*;

  localparam int N = 3;

  logic        clk = 1'b0;
  logic        rst;
  PageWalk_Req req [N];
  logic [N-1:0] grant;
  logic [N-1:0] cancel;
  logic        clear;
  PageWalk_Req walk;
  logic [1:0]  walk_id;
  logic        walk_done;
  PageWalk_Res walk_res;
  PageWalk_Res res;
  logic        res_valid;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [1:0]  id;
    logic [31:0] vaddr;
  } walk_exp_t;

  typedef struct {
    logic [1:0]  id;
    logic [19:0] ppn;
    logic        fault;
  } res_exp_t;

  typedef struct {
    string    name;
    logic [N-1:0] req_m;
    logic [N-1:0] cancel_m;
    logic [N-1:0] exp_g;
  } vec_t;

  walk_exp_t walk_q[$];
  res_exp_t  res_q[$];
  walk_exp_t we;
  res_exp_t  re;
  vec_t      vecs[$];

  always #5 clk = ~clk;

  pw_arbiter #(.NUM_RQ(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .IN_req       (req),
    .OUT_grant    (grant),
    .IN_cancel    (cancel),
    .IN_clear     (clear),
    .OUT_walk     (walk),
    .OUT_walkRqID (walk_id),
    .IN_walkDone  (walk_done),
    .IN_walkRes   (walk_res),
    .OUT_res      (res),
    .OUT_resValid (res_valid)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] oh_to_id(input logic [N-1:0] oh);
    logic [1:0] id;
    id = 2'd0;
    for (int i = 0; i < N; i++) if (oh[i]) id = 2'(i);
    return id;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [N-1:0] m);
    for (int i = 0; i < N; i++) begin
      req[i].valid = m[i];
      req[i].vaddr = $urandom();
    end
  endtask

  task automatic finish_walk(input string name, input logic [1:0] id);
    tick();
    tick();
    walk_done      = 1'b1;
    walk_res.ppn   = 20'($urandom());
    walk_res.fault = 1'($urandom());
    walk_res.vaddr = $urandom();
    res_q.push_back('{id, walk_res.ppn, walk_res.fault});
    tick();
    walk_done = 1'b0;
    check({name, "_busy_after"}, res.busy, 1'b0);
  endtask

  // One arbitration attempt from IDLE; a granted walk is run to completion.
  task automatic do_walk(input string name, input logic [N-1:0] req_m,
                         input logic [N-1:0] cancel_m, input logic [N-1:0] exp_g);
    logic [1:0] id;
    set_req(req_m);
    cancel = cancel_m;
    #1;
    check({name, "_grant"}, grant, exp_g);
    if (exp_g != '0) begin
      id = oh_to_id(exp_g);
      walk_q.push_back('{id, req[id].vaddr});
      tick();
      set_req('0);
      cancel = '0;
      check({name, "_busy"}, res.busy, 1'b1);
      check({name, "_rqid"}, res.rqID, id);
      finish_walk(name, id);
    end else begin
      tick();
      set_req('0);
      cancel = '0;
      check({name, "_idle_busy"}, res.busy, 1'b0);
    end
  endtask

  // Scoreboard: every walk issue and every delivered result must match a queued expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (walk.valid) begin
        if (walk_q.size() == 0) begin
          check("walk_unexpected", 1, 0);
        end else begin
          we = walk_q.pop_front();
          check("walk_id", walk_id, we.id);
          check("walk_vaddr", walk.vaddr, we.vaddr);
        end
      end
      if (res_valid) begin
        if (res_q.size() == 0) begin
          check("res_unexpected", 1, 0);
        end else begin
          re = res_q.pop_front();
          check("res_id", res.rqID, re.id);
          check("res_ppn", res.ppn, re.ppn);
          check("res_fault", res.fault, re.fault);
          check("res_busy", res.busy, 1'b0);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    cancel    = '0;
    clear     = 1'b0;
    walk_done = 1'b0;
    walk_res  = '0;
    set_req('0);
    repeat (3) tick();
    rst = 1'b0;
    tick();

    check("reset_grant", grant, '0);
    check("reset_walk_valid", walk.valid, 1'b0);
    check("reset_res_valid", res_valid, 1'b0);
    check("reset_busy", res.busy, 1'b0);

    // rrPtr starts at 0; comments give pointer after each row.
    vecs.push_back('{"rr0",        3'b111, 3'b000, 3'b001}); // ptr 1
    vecs.push_back('{"rr1",        3'b110, 3'b000, 3'b010}); // ptr 2
    vecs.push_back('{"rr2",        3'b100, 3'b000, 3'b100}); // ptr 0
    vecs.push_back('{"rr3",        3'b110, 3'b000, 3'b010}); // ptr 2
    vecs.push_back('{"rr4",        3'b100, 3'b000, 3'b100}); // ptr 0
    vecs.push_back('{"rr5_new0",   3'b111, 3'b000, 3'b001}); // ptr 1
    vecs.push_back('{"cancel_gnt", 3'b010, 3'b010, 3'b000}); // ptr 1
    vecs.push_back('{"rr6",        3'b101, 3'b000, 3'b100}); // ptr 0
    vecs.push_back('{"cancel_mix", 3'b110, 3'b010, 3'b100}); // ptr 0
    vecs.push_back('{"rr7",        3'b011, 3'b000, 3'b001}); // ptr 1
    foreach (vecs[k]) do_walk(vecs[k].name, vecs[k].req_m, vecs[k].cancel_m, vecs[k].exp_g);

    // Cancel in flight: result suppressed, then ID 1 wins next.
    set_req(3'b100);
    #1;
    check("cif_grant", grant, 3'b100);
    walk_q.push_back('{2'd2, req[2].vaddr});
    tick();
    set_req('0);
    tick();
    cancel = 3'b100;
    tick();
    cancel    = '0;
    walk_done = 1'b1;
    tick();
    walk_done = 1'b0;
    check("cif_res_valid", res_valid, 1'b0);
    check("cif_busy", res.busy, 1'b0);
    do_walk("cif_next", 3'b010, 3'b000, 3'b010); // ptr 2

    // Clear coinciding with walkDone: suppressed result and one DRAIN cycle.
    set_req(3'b001);
    #1;
    check("clr_grant", grant, 3'b001);
    walk_q.push_back('{2'd0, req[0].vaddr});
    tick();
    set_req('0);
    tick();
    tick();
    walk_done = 1'b1;
    clear     = 1'b1;
    tick();
    walk_done = 1'b0;
    clear     = 1'b0;
    check("clr_res_valid", res_valid, 1'b0);
    check("clr_drain_busy", res.busy, 1'b1);
    set_req(3'b001);
    #1;
    check("clr_drain_grant", grant, '0);
    tick();
    check("clr_post_busy", res.busy, 1'b0);
    do_walk("clr_post", 3'b001, 3'b000, 3'b001); // ptr 1

    // Reset mid-walk: outputs return to reset values, late done ignored, rrPtr back to 0.
    set_req(3'b010);
    #1;
    check("rst_grant", grant, 3'b010);
    walk_q.push_back('{2'd1, req[1].vaddr});
    tick();
    set_req('0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_walk_valid", walk.valid, 1'b0);
    check("rst_mid_res_valid", res_valid, 1'b0);
    check("rst_mid_busy", res.busy, 1'b0);
    walk_done = 1'b1;
    tick();
    walk_done = 1'b0;
    check("rst_late_res_valid", res_valid, 1'b0);
    check("rst_late_busy", res.busy, 1'b0);
    do_walk("rst_ptr0", 3'b111, 3'b000, 3'b001);

    tick();
    check("walk_q_empty", walk_q.size(), 0);
    check("res_q_empty", res_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pw_arbiter.md
# pw_arbiter

Shares the single hardware page walker between the instruction-fetch TLB and the data TLBs (load and store ports). Requesters raise page-walk requests, and the block grants one at a time in round-robin order. It tags the issued walk with the requester's ID, tracks the walk until completion, and broadcasts the tagged result and busy status back to all requesters. It sits between the per-port TLB miss handlers and the page walker, and replaces the walker's direct single-requester hookup.

## Interface
- NUM_RQ, default 3: number of requesters; ID 0 is instruction fetch, 1 and up are data ports.
- ID_W, default $clog2(NUM_RQ): requester ID width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- IN_req  in  NUM_RQ x PageWalk_Req  per-requester walk request; the valid field is held until granted.
- OUT_grant  out  NUM_RQ  one-hot, one-cycle pulse; the request is accepted and the requester may deassert.
- IN_cancel  in  NUM_RQ  per-requester flush (mispredict or pipeline flush); drops that requester's pending request or in-flight result.
- IN_clear  in  1  TLB flush or SATP write; drops any in-flight result globally.
- OUT_walk  out  PageWalk_Req  request to the walker; valid for exactly one cycle per walk.
- OUT_walkRqID  out  ID_W  ID accompanying OUT_walk.
- IN_walkDone  in  1  walker result valid (one-cycle pulse).
- IN_walkRes  in  PageWalk_Res  walker result payload.
- OUT_res  out  PageWalk_Res  broadcast result; the busy and rqID fields are driven by this block.
- OUT_resValid  out  1  result valid for the requester named by OUT_res.rqID.

## Operation
States: IDLE, ISSUE, WAIT, DRAIN.

- **IDLE**
  - Candidates: IN_req[i].valid && !IN_cancel[i].
  - Winner: the first candidate at or after rrPtr, wrapping modulo NUM_RQ.
  - On a winner:
    - Latch the request and ID.
    - Pulse OUT_grant[winner].
    - Set rrPtr = winner+1, wrapping to 0 at NUM_RQ.
    - Go to ISSUE.
- **ISSUE**
  - Drive OUT_walk.valid=1 with the latched request and OUT_walkRqID.
  - Go to WAIT.
- **WAIT**
  - On IN_walkDone: if the result is not stale, drive it as OUT_res with OUT_resValid=1 next cycle. Go to IDLE.
  - IN_cancel[curID] or IN_clear while in ISSUE or WAIT sets the stale flag. The walk still runs to completion (the walker cannot abort), but its result is suppressed (OUT_resValid=0).
- **DRAIN**
  - Entered from WAIT only if IN_walkDone and a new IN_clear coincide.
  - Behaves as IDLE without granting for one cycle, so no request is granted in the same cycle a clear is observed.
- **Busy status**
  - OUT_res.busy=1 in ISSUE, WAIT and DRAIN.
  - OUT_res.rqID = the latched ID whenever busy.
  - TLBs stall their own port while busy && rqID==own ID.
- Requests from non-winners stay pending; nothing is queued internally (one walk outstanding).
- IN_cancel[i] in the same cycle as that requester would win: the requester is not a candidate and no grant is issued to it.

## Timing
- Reset values:
  - state=IDLE, rrPtr=0, stale=0
  - OUT_grant=0, OUT_walk.valid=0, OUT_resValid=0, OUT_res.busy=0
  - OUT_walkRqID and the other payloads are don't-care ('x).
- Latency:
  - Request seen in IDLE at cycle N: OUT_grant at N (combinational), OUT_walk.valid at N+1, OUT_res.busy from N+1.
  - IN_walkDone at cycle M: OUT_resValid at M+1.
  - Earliest next grant is M+1; the next OUT_walk is at M+2.
- OUT_walk.valid, OUT_res and OUT_resValid are registered. OUT_grant is combinational from IN_req, IN_cancel and the state.
- Round-robin: after granting ID k, the priority order is k+1, …, NUM_RQ-1, 0, …, k. No requester waits more than NUM_RQ-1 walks.
- Reset mid-walk: the block returns to IDLE immediately. A late IN_walkDone is ignored in IDLE and produces no OUT_resValid.
- IN_walkDone outside WAIT is ignored and triggers an assertion.

## Structure
- Add PageWalk_Req, PageWalk_Res and the RQ ID constants (RQ_IFETCH=0, RQ_LOAD=1, RQ_STORE=2) to the shared package. ICacheTable's RQ_ID parameter takes RQ_IFETCH.
- Sub-module: rr_picker (parameterised NUM_RQ round-robin one-hot picker, inputs mask and ptr). It is reusable by other arbiters.

## Test plan
- **Single request:** req[0] valid at cycle 10 → grant[0] at 10; OUT_walk.valid at 11 with rqID 0; busy=1 from 11. walkDone at 20 → OUT_resValid at 21 with rqID 0; busy=0 at 21.
- **Contention:** req[0], req[1] and req[2] held from rrPtr=0 → grant order 0,1,2. Next round with req[1] and req[2] held → order 1,2 without skipping. A new req[0] after ID 2's grant is granted next.
- **Cancel in flight:** grant to 2; IN_cancel[2] in WAIT → walkDone produces OUT_resValid=0 and busy drops the next cycle. ID 1 is granted at the following IDLE cycle.
- **Clear coinciding with done:** IN_clear and walkDone in the same cycle → OUT_resValid=0, DRAIN for 1 cycle, no grant during DRAIN.
- **Reset mid-walk:** rst during WAIT → all outputs return to reset values next cycle. A subsequent walkDone produces no OUT_resValid, and the assertion fires only if it is not masked after reset.
- **Cancel at grant:** req[1] valid with IN_cancel[1] in IDLE → no grant, rrPtr unchanged.
